// File: rtl/shared_reg_arbiter_if.sv
// Bus bundle between NREQ requesters and the shared output register arbiter.
// master: requester side (drives REQ/WE/DIN), slave: arbiter side.
interface shared_reg_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    REQ;
    logic [NREQ-1:0]    WE;
    logic [NREQ*DW-1:0] DIN;
    logic [NREQ-1:0]    GNT;
    logic [IDW-1:0]     OWNER;
    logic               BUSY;
    logic               ACK;
    logic [DW-1:0]      Q;
    logic               TOUT;

    modport master (
        output REQ, WE, DIN,
        input  GNT, OWNER, BUSY, ACK, Q, TOUT
    );

    modport slave (
        input  REQ, WE, DIN,
        output GNT, OWNER, BUSY, ACK, Q, TOUT
    );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one registered output port among NREQ requesters.
// A requester owns the port while it holds its REQ bit; its writes load Q.
// After each release there is one GAP cycle before arbitration resumes, and the
// search pointer moves just past the last owner.
// Optional build macro ARB_TIMEOUT_EN: revoke the grant from an owner that sits
// MAX_HOLD edges without writing, pulsing TOUT.
module shared_reg_arbiter #(
    parameter int            NREQ     = 4,
    parameter int            IDW      = 2,
    parameter int            DW       = 8,
    parameter logic [DW-1:0] INIT_VAL = 8'hFF,
    parameter int            MAX_HOLD = 15
) (
    input logic               C,
    input logic               CLR,
    shared_reg_arbiter_if.slave bus
);

    if (NREQ < 2 || NREQ > 8 || (2 ** IDW) < NREQ || MAX_HOLD < 1) begin : g_bad_param
        $error("shared_reg_arbiter: invalid parameter set");
    end

    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

    localparam logic [IDW:0]   NREQ_W = (IDW + 1)'(NREQ);
    localparam logic [IDW-1:0] LAST   = IDW'(NREQ - 1);

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] gnt_r;
    logic [IDW-1:0]  owner_r;
    logic            busy_r;
    logic            ack_r;
    logic [DW-1:0]   q_r;

    logic [IDW-1:0]  winner;
    logic            any_req;
    logic            own_held;
    logic            wr_ok;
    logic [DW-1:0]   wr_data;
    logic [IDW-1:0]  next_ptr;

`ifdef ARB_TIMEOUT_EN
    localparam int             HOLD_W    = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    logic [HOLD_W-1:0] hold_cnt;
    logic              tout_r;
`endif

    // Rotating priority scan: first set REQ bit starting at ptr, wrapping at NREQ.
    always_comb begin
        logic [IDW:0] idx;
        idx     = '0;
        winner  = '0;
        any_req = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (IDW + 1)'(k);
            if (idx >= NREQ_W) begin
                idx = idx - NREQ_W;
            end
            if (bus.REQ[idx[IDW-1:0]]) begin
                winner  = idx[IDW-1:0];
                any_req = 1'b1;
            end
        end
    end

    assign own_held = bus.REQ[owner_r];
    assign wr_ok    = own_held & bus.WE[owner_r];
    assign wr_data  = bus.DIN[int'(owner_r) * DW +: DW];
    assign next_ptr = (owner_r == LAST) ? '0 : owner_r + 1'b1;

    // Arbitration FSM with registered grant, acknowledge and shared data register.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt_r   <= '0;
            owner_r <= '0;
            busy_r  <= 1'b0;
            ack_r   <= 1'b0;
            q_r     <= INIT_VAL;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
            tout_r   <= 1'b0;
`endif
        end else begin
            ack_r <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tout_r <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_r   <= NREQ'(1) << winner;
                        owner_r <= winner;
                        busy_r  <= 1'b1;
                        state   <= OWN;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end
                end
                OWN: begin
                    if (!own_held) begin
                        gnt_r  <= '0;
                        busy_r <= 1'b0;
                        ptr    <= next_ptr;
                        state  <= GAP;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end else if (wr_ok) begin
                        q_r   <= wr_data;
                        ack_r <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        // Owner idle for MAX_HOLD edges: revoke like a REQ drop.
                        gnt_r    <= '0;
                        busy_r   <= 1'b0;
                        ptr      <= next_ptr;
                        state    <= GAP;
                        hold_cnt <= '0;
                        tout_r   <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
`endif
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.GNT   = gnt_r;
    assign bus.OWNER = owner_r;
    assign bus.BUSY  = busy_r;
    assign bus.ACK   = ack_r;
    assign bus.Q     = q_r;
`ifdef ARB_TIMEOUT_EN
    assign bus.TOUT  = tout_r;
`else
    assign bus.TOUT  = 1'b0;
`endif

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: directed scenarios plus random
// traffic, compared every edge against a behavioural model of the arbiter rules.
module tb_shared_reg_arbiter;

    localparam int         NREQ     = 4;
    localparam int         IDW      = 2;
    localparam int         DW       = 8;
    localparam int         MAX_HOLD = 15;
    localparam logic [7:0] INIT_VAL = 8'hFF;

    logic C = 1'b0;
    logic CLR;

    always #5 C = ~C;

    shared_reg_arbiter_if #(.NREQ(NREQ), .IDW(IDW), .DW(DW)) bus ();

    shared_reg_arbiter #(
        .NREQ(NREQ), .IDW(IDW), .DW(DW), .INIT_VAL(INIT_VAL), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .C(C),
        .CLR(CLR),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: 0 = idle, 1 = owned, 2 = gap
    int         m_state;
    int         m_owner;
    int         m_ptr;
    int         m_hold;
    logic [7:0] m_q;
    bit         m_ack;
    bit         m_tout;
    int         edge_no = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_gnt();
        return (m_state == 1) ? 4'(1 << m_owner) : 4'b0000;
    endfunction

    function automatic void model_reset();
        m_state = 0;
        m_owner = 0;
        m_ptr   = 0;
        m_hold  = 0;
        m_q     = INIT_VAL;
        m_ack   = 0;
        m_tout  = 0;
    endfunction

    function automatic void model_release();
        m_ptr   = (m_owner + 1) % NREQ;
        m_state = 2;
        m_hold  = 0;
    endfunction

    function automatic void model_step(input logic [3:0] req, input logic [3:0] we,
                                       input logic [31:0] din);
        m_ack  = 0;
        m_tout = 0;
        case (m_state)
            0: begin
                for (int k = 0; k < NREQ; k++) begin
                    if (m_state == 0 && req[(m_ptr + k) % NREQ]) begin
                        m_owner = (m_ptr + k) % NREQ;
                        m_state = 1;
                        m_hold  = 0;
                    end
                end
            end
            1: begin
                if (!req[m_owner]) begin
                    model_release();
                end else if (we[m_owner]) begin
                    m_q    = din[m_owner*8 +: 8];
                    m_ack  = 1;
                    m_hold = 0;
                end else begin
`ifdef ARB_TIMEOUT_EN
                    m_hold++;
                    if (m_hold == MAX_HOLD) begin
                        model_release();
                        m_tout = 1;
                    end
`endif
                end
            end
            default: m_state = 0;
        endcase
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".gnt"},   32'(bus.GNT),   32'(m_gnt()));
        check({tag, ".owner"}, 32'(bus.OWNER), 32'(m_owner));
        check({tag, ".busy"},  32'(bus.BUSY),  32'(m_state == 1));
        check({tag, ".ack"},   32'(bus.ACK),   32'(m_ack));
        check({tag, ".q"},     32'(bus.Q),     32'(m_q));
        check({tag, ".tout"},  32'(bus.TOUT),  32'(m_tout));
    endtask

    // One clock edge: model follows the inputs present at the edge, outputs checked 1 time unit later.
    task automatic step(input string tag);
        @(posedge C);
        edge_no++;
        if (!CLR) model_step(bus.REQ, bus.WE, bus.DIN);
        #1;
        check_all(tag);
    endtask

    // Assert CLR between edges; outputs must already be at reset values.
    task automatic clr_assert(input string tag);
        #2;
        CLR = 1'b1;
        model_reset();
        #1;
        check_all(tag);
    endtask

    task automatic idle_out(input string tag);
        bus.REQ = '0;
        bus.WE  = '0;
        repeat (3) step(tag);
    endtask

    initial begin
        int         since;
        int         gcount;
        int         rel_edge;
        int         g_edge[$];
        int         r_edge[$];
        logic [3:0] g_val[$];
        logic [3:0] exp_order[5];
        logic       prev_busy;
        logic [7:0] q_before;

        exp_order[0] = 4'b0001;
        exp_order[1] = 4'b0010;
        exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000;
        exp_order[4] = 4'b0001;

        bus.REQ = '0;
        bus.WE  = '0;
        bus.DIN = '0;
        CLR     = 1'b1;
        model_reset();
        #1;
        check_all("reset");
        #20;
        @(negedge C);
        CLR = 1'b0;

        // Single grant and write
        bus.REQ = 4'b0010;
        step("grant1");
        check("grant1_gnt", 32'(bus.GNT), 32'h2);
        check("grant1_owner", 32'(bus.OWNER), 32'h1);
        bus.WE  = 4'b0010;
        bus.DIN = 32'h0000_5A00;
        step("write5a");
        check("write5a_q", 32'(bus.Q), 32'h5A);
        check("write5a_ack", 32'(bus.ACK), 32'h1);
        bus.WE = 4'b0000;
        step("ack_drop");
        check("ack_pulse_end", 32'(bus.ACK), 32'h0);

        // Async reset after Q=12
        bus.WE  = 4'b0010;
        bus.DIN = 32'h0000_1200;
        step("write12");
        check("write12_q", 32'(bus.Q), 32'h12);
        bus.WE = 4'b0000;
        clr_assert("async_clr");
        check("async_clr_q", 32'(bus.Q), 32'hFF);
        check("async_clr_gnt", 32'(bus.GNT), 32'h0);
        check("async_clr_busy", 32'(bus.BUSY), 32'h0);
        step("clr_held");
        step("clr_held");
        check("clr_held_q", 32'(bus.Q), 32'hFF);
        CLR     = 1'b0;
        bus.REQ = 4'b0000;
        step("post_clr");

        // Round robin: each owner drops its bit 2 edges after grant, re-raises next cycle
        since     = -1;
        gcount    = 0;
        prev_busy = bus.BUSY;
        for (int e = 0; e < 60 && gcount < 5; e++) begin
            bus.REQ = 4'b1111;
            if (m_state == 1 && since == 1) bus.REQ[m_owner] = 1'b0;
            step("rr");
            if (bus.BUSY && !prev_busy) begin
                g_edge.push_back(edge_no);
                g_val.push_back(bus.GNT);
                gcount++;
            end
            if (!bus.BUSY && prev_busy) r_edge.push_back(edge_no);
            prev_busy = bus.BUSY;
            if (m_state == 1) since++;
            else since = -1;
            if (m_state == 1 && since > 0 && m_ack == 0 && since == 0) since = 0;
            if (bus.BUSY && g_edge.size() > 0 && g_edge[$] == edge_no) since = 0;
        end
        check("rr_grant_count", 32'(gcount), 32'd5);
        for (int i = 0; i < 5 && i < g_val.size(); i++) begin
            check($sformatf("rr_order%0d", i), 32'(g_val[i]), 32'(exp_order[i]));
        end
        for (int i = 1; i < g_edge.size() && i - 1 < r_edge.size(); i++) begin
            rel_edge = r_edge[i-1];
            check($sformatf("rr_gap%0d", i), 32'(g_edge[i] - rel_edge), 32'd2);
        end
        idle_out("rr_end");

        // Non-owner write ignored
        bus.REQ = 4'b0100;
        step("own2");
        check("own2_owner", 32'(bus.OWNER), 32'h2);
        q_before = bus.Q;
        bus.WE   = 4'b0001;
        bus.DIN  = 32'h0000_0033;
        step("nonowner_we");
        check("nonowner_q", 32'(bus.Q), 32'(q_before));
        check("nonowner_ack", 32'(bus.ACK), 32'h0);
        idle_out("nonowner_end");

        // Reset mid-ownership with a pending write
        bus.REQ = 4'b1000;
        step("own3");
        check("own3_gnt", 32'(bus.GNT), 32'h8);
        bus.WE  = 4'b1000;
        bus.DIN = 32'hAB00_0000;
        clr_assert("mid_clr");
        check("mid_clr_q", 32'(bus.Q), 32'hFF);
        check("mid_clr_owner", 32'(bus.OWNER), 32'h0);
        step("mid_clr_held");
        CLR     = 1'b0;
        bus.WE  = 4'b0000;
        bus.REQ = 4'b0100;
        step("after_clr_grant");
        check("after_clr_gnt", 32'(bus.GNT), 32'h4);
        idle_out("mid_clr_end");

        // Idle owner hold / timeout
        bus.REQ = 4'b0010;
        step("hold_grant");
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i < MAX_HOLD; i++) step("hold_idle");
        check("hold_pre_tout_gnt", 32'(bus.GNT), 32'h2);
        step("tout_edge");
        check("tout_gnt", 32'(bus.GNT), 32'h0);
        check("tout_pulse", 32'(bus.TOUT), 32'h1);
        step("tout_after");
        check("tout_one_cycle", 32'(bus.TOUT), 32'h0);
`else
        repeat (100) step("hold_idle");
        check("hold_gnt", 32'(bus.GNT), 32'h2);
        check("hold_tout", 32'(bus.TOUT), 32'h0);
`endif
        idle_out("hold_end");

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < NREQ; b++) begin
                if ($urandom_range(0, 5) == 0) bus.REQ[b] = ~bus.REQ[b];
            end
            bus.WE  = 4'($urandom_range(0, 15));
            bus.DIN = $urandom;
            if ($urandom_range(0, 99) == 0) begin
                clr_assert("rand_clr");
                step("rand_clr_held");
                CLR = 1'b0;
            end else begin
                step("rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
